// File: rtl/pingpong_input_bank_buffer.sv
// Double-buffered (A/B) input feature-map buffer. The loader fills one buffer
// while the PE side drains the other; ownership of each buffer is tracked by a
// small per-buffer FSM and the write/read selects swap on the tile-last markers.
module pingpong_input_bank_buffer #(
  parameter int WORD_SIZE = 16,
  parameter int NUM_BANKS = 3,
  parameter int DEPTH     = 4096,
  parameter int ADDR_W    = 12,
  parameter int BSEL_W    = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           cfg_1x1,
  input  logic [BSEL_W:0]                icp_count,
  input  logic                           wr_valid,
  output logic                           wr_ready,
  input  logic [WORD_SIZE-1:0]           wr_data,
  input  logic [BSEL_W-1:0]              wr_bank,
  input  logic [ADDR_W-1:0]              wr_addr,
  input  logic                           wr_zero,
  input  logic                           wr_last,
  input  logic                           rd_en,
  output logic                           rd_ready,
  input  logic [ADDR_W-1:0]              rd_addr,
  input  logic [NUM_BANKS-1:0]           rd_pad,
  input  logic                           rd_last,
  output logic                           rd_valid,
  output logic [NUM_BANKS*WORD_SIZE-1:0] rd_data,
  output logic                           rd_sel,
  output logic                           bank_err
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FILL  = 2'd1,
    ST_READY = 2'd2,
    ST_DRAIN = 2'd3
  } buf_state_e;

  buf_state_e st_q [2];
  buf_state_e st_d [2];

  logic                           wsel_q, wsel_d;
  logic                           rsel_q, rsel_d;
  logic [BSEL_W-1:0]              cnt_q, cnt_d;
  logic                           mode_q, mode_d;
  logic [BSEL_W:0]                icp_q, icp_d;
  logic                           bank_err_q, bank_err_d;
  logic                           rd_valid_q, rd_valid_d;
  logic [NUM_BANKS*WORD_SIZE-1:0] rd_data_q, rd_data_d;

  // Storage: [buffer][bank][address]; contents are never reset.
  logic signed [WORD_SIZE-1:0] mem [2][NUM_BANKS][DEPTH];

  logic                        wr_acc, rd_acc, tile_start;
  logic                        mode_eff, bank_oob, zero_fill, mem_we;
  logic [BSEL_W:0]             icp_eff;
  logic [BSEL_W-1:0]           wbank;
  logic signed [WORD_SIZE-1:0] wdata;

  // Handshakes, tile-config capture and write-path decode.
  always_comb begin
    wr_ready   = (st_q[wsel_q] == ST_EMPTY) || (st_q[wsel_q] == ST_FILL);
    rd_ready   = (st_q[rsel_q] == ST_READY) || (st_q[rsel_q] == ST_DRAIN);
    wr_acc     = wr_valid && wr_ready;
    rd_acc     = rd_en && rd_ready;
    // The first write of a tile uses the live config; later writes use the captured copy.
    tile_start = wr_acc && (st_q[wsel_q] == ST_EMPTY);
    mode_eff   = tile_start ? cfg_1x1 : mode_q;
    icp_eff    = tile_start ? icp_count : icp_q;
    bank_oob   = ({1'b0, wr_bank} >= (BSEL_W + 1)'(NUM_BANKS));
    wbank      = mode_eff ? cnt_q : wr_bank;
    zero_fill  = wr_zero || (mode_eff && ({1'b0, cnt_q} >= icp_eff));
    wdata      = zero_fill ? '0 : wr_data;
    // An out-of-range explicit bank still completes the handshake but stores nothing.
    mem_we     = wr_acc && (mode_eff || !bank_oob);
  end

  // Next-state for both buffer FSMs, selects, bank counter and read path.
  always_comb begin
    st_d[0]    = st_q[0];
    st_d[1]    = st_q[1];
    wsel_d     = wsel_q;
    rsel_d     = rsel_q;
    cnt_d      = cnt_q;
    mode_d     = mode_q;
    icp_d      = icp_q;
    bank_err_d = bank_err_q;
    rd_valid_d = rd_acc;
    rd_data_d  = rd_data_q;

    if (wr_acc) begin
      if (wr_last) begin
        st_d[wsel_q] = ST_READY;
        wsel_d       = ~wsel_q;
        cnt_d        = '0;
      end else begin
        if (st_q[wsel_q] == ST_EMPTY) st_d[wsel_q] = ST_FILL;
        if (mode_eff) cnt_d = (cnt_q == BSEL_W'(NUM_BANKS - 1)) ? '0 : cnt_q + 1'b1;
      end
      if (tile_start) begin
        mode_d = cfg_1x1;
        icp_d  = icp_count;
      end
      if (!mode_eff && bank_oob) bank_err_d = 1'b1;
    end

    // Write and read never own the same buffer, so these updates cannot collide.
    if (rd_acc) begin
      if (rd_last) begin
        st_d[rsel_q] = ST_EMPTY;
        rsel_d       = ~rsel_q;
      end else if (st_q[rsel_q] == ST_READY) begin
        st_d[rsel_q] = ST_DRAIN;
      end
      for (int k = 0; k < NUM_BANKS; k++) begin
        rd_data_d[k*WORD_SIZE +: WORD_SIZE] = rd_pad[k] ? '0 : mem[rsel_q][k][rd_addr];
      end
    end
  end

  // Control and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_q[0]    <= ST_EMPTY;
      st_q[1]    <= ST_EMPTY;
      wsel_q     <= 1'b0;
      rsel_q     <= 1'b0;
      cnt_q      <= '0;
      mode_q     <= 1'b0;
      icp_q      <= '0;
      bank_err_q <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      st_q[0]    <= st_d[0];
      st_q[1]    <= st_d[1];
      wsel_q     <= wsel_d;
      rsel_q     <= rsel_d;
      cnt_q      <= cnt_d;
      mode_q     <= mode_d;
      icp_q      <= icp_d;
      bank_err_q <= bank_err_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  // Memory write into the buffer currently owned by the loader.
  always_ff @(posedge clk) begin
    if (mem_we) mem[wsel_q][wbank][wr_addr] <= wdata;
  end

  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;
  assign rd_sel   = rsel_q;
  assign bank_err = bank_err_q;

endmodule
